// File: rtl/delta_frame_reader.sv
// delta_frame_reader: re-reads ring-buffer frames t-2,t-1,t+1,t+2 per coefficient and emits the delta cepstrum
// for each target frame once the writer has delivered frame t+2.
module delta_frame_reader #(
    parameter int FRAME_W  = 7,
    parameter int COEF_W   = 4,
    parameter int NUM_COEF = 13,
    parameter int DATA_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_W-1:0]    last_frame,
    input  logic                  wr_frame_done,
    output logic                  rd_en,
    output logic [COEF_W+2:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic                  delta_valid,
    output logic [DATA_W+2:0]     delta_out,
    output logic [COEF_W-1:0]     delta_coef,
    output logic [FRAME_W-1:0]    delta_frame,
    output logic [FRAME_W-1:0]    oldest_needed,
    output logic                  busy,
    output logic                  done
);
    localparam int ACC_W = DATA_W + 3;
    typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, DONE} state_t;
    state_t state;
    logic [FRAME_W:0]          wr_cnt;
    logic [FRAME_W-1:0]        t, last_q, f1, f2;
    logic [COEF_W-1:0]         k, k1, k2;
    logic [1:0]                p, p1, p2;
    logic                      v2;
    logic signed [ACC_W-1:0]   acc, d;
    logic [2:0]                slot;
    logic                      last_rd;
    logic [FRAME_W:0]          t_ext;
    assign d       = {{3{rd_data[DATA_W-1]}}, rd_data};
    assign t_ext   = {1'b0, t};
    // phase order p0..p3 reads frames t+2, t-2, t+1, t-1; offsets taken mod 8 for the ring slot
    assign slot    = t[2:0] + (p == 2'd0 ? 3'd2 : p == 2'd1 ? 3'd6 : p == 2'd2 ? 3'd1 : 3'd7);
    assign last_rd = (k == COEF_W'(NUM_COEF - 1)) && (p == 2'd3);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            t             <= FRAME_W'(2);
            last_q        <= '0;
            k             <= '0;
            p             <= '0;
            k1            <= '0;
            k2            <= '0;
            p1            <= '0;
            p2            <= '0;
            f1            <= '0;
            f2            <= '0;
            v2            <= 1'b0;
            acc           <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            delta_valid   <= 1'b0;
            delta_out     <= '0;
            delta_coef    <= '0;
            delta_frame   <= '0;
            oldest_needed <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            rd_en       <= 1'b0;
            v2          <= rd_en;
            p2          <= p1;
            k2          <= k1;
            f2          <= f1;
            delta_valid <= 1'b0;
            done        <= 1'b0;
            if (wr_frame_done && wr_cnt <= {1'b0, last_q})
                wr_cnt <= wr_cnt + 1'b1;
            if (v2) begin
                case (p2)
                    2'd0: acc <= d <<< 1;
                    2'd1: acc <= acc - (d <<< 1);
                    2'd2: acc <= acc + d;
                    default: begin
                        delta_out   <= acc - d;
                        delta_valid <= 1'b1;
                        delta_coef  <= k2;
                        delta_frame <= f2;
                    end
                endcase
            end
            // start overrides everything, including an utterance already in progress
            if (start) begin
                last_q        <= last_frame;
                t             <= FRAME_W'(2);
                wr_cnt        <= '0;
                busy          <= 1'b1;
                oldest_needed <= '0;
                v2            <= 1'b0;
                delta_valid   <= 1'b0;
                state         <= last_frame < FRAME_W'(4) ? DONE : WAIT;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    WAIT: begin
                        if (wr_cnt >= t_ext + (FRAME_W+1)'(3)) begin
                            state <= READ;
                            k     <= '0;
                            p     <= '0;
                        end
                    end
                    READ: begin
                        rd_en   <= 1'b1;
                        rd_addr <= {slot, k};
                        p1      <= p;
                        k1      <= k;
                        f1      <= t;
                        p       <= p + 2'd1;
                        if (p == 2'd3)
                            k <= k + 1'b1;
                        if (last_rd) begin
                            if (t_ext + (FRAME_W+1)'(2) < {1'b0, last_q}) begin
                                state         <= WAIT;
                                t             <= t + 1'b1;
                                oldest_needed <= t - 1'b1;
                            end else
                                state <= DRAIN;
                        end
                    end
                    DRAIN: if (delta_valid) state <= DONE;
                    DONE: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_delta_frame_reader.sv
// tb_delta_frame_reader: directed tests with a behavioural ring RAM and hand-computed delta values.
module tb_delta_frame_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  last_frame = '0;
    logic        wr_frame_done = 1'b0;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data = '0;
    logic        delta_valid;
    logic [18:0] delta_out;
    logic [3:0]  delta_coef;
    logic [6:0]  delta_frame;
    logic [6:0]  oldest_needed;
    logic        busy;
    logic        done;
    logic [15:0] ram [0:127];
    logic        clr = 1'b0;
    int tests = 0, fails = 0;
    int n_valid, n_done, n_rd, n_busy;
    int vout [0:127];
    int vcoef [0:127];
    int vframe [0:127];
    int von [0:127];

    delta_frame_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_frame(last_frame),
        .wr_frame_done(wr_frame_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .delta_valid(delta_valid), .delta_out(delta_out), .delta_coef(delta_coef),
        .delta_frame(delta_frame), .oldest_needed(oldest_needed), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    always @(negedge clk) begin
        if (clr) begin
            n_valid = 0;
            n_done  = 0;
            n_rd    = 0;
            n_busy  = 0;
        end else begin
            if (delta_valid) begin
                if (n_valid < 128) begin
                    vout[n_valid]   = $signed(delta_out);
                    vcoef[n_valid]  = int'(delta_coef);
                    vframe[n_valid] = int'(delta_frame);
                    von[n_valid]    = int'(oldest_needed);
                end
                n_valid++;
            end
            if (done) n_done++;
            if (rd_en) n_rd++;
            if (busy) n_busy++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic pulse_start(input int lf);
        @(posedge clk);
        #1 start = 1'b1;
        last_frame = 7'(lf);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_wr(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 wr_frame_done = 1'b1;
            @(posedge clk);
            #1 wr_frame_done = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == budget) check({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < 128; a++) ram[a] = 16'(a);
    endtask

    task automatic fill_extreme();
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 16; c++)
                ram[f*16+c] = (f == 3 || f == 4) ? (c[0] ? 16'h8000 : 16'h7FFF) :
                              (f == 0 || f == 1) ? (c[0] ? 16'h7FFF : 16'h8000) : 16'h0000;
    endtask

    initial begin
        int bad, base;
        fill_ramp();
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(delta_valid), 0);
        check("rst_oldest", int'(oldest_needed), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 clr = 1'b0;

        // ramp c[f][k] = 16f+k: delta = 2*64 + 32 = 160 everywhere
        clear_stats();
        pulse_start(6);
        pulse_wr(7);
        wait_done("t1", 1000);
        check("t1_count", n_valid, 39);
        bad = 0;
        for (int i = 0; i < 39; i++)
            if (vout[i] != 160 || vcoef[i] != i % 13 || vframe[i] != 2 + i / 13) bad++;
        check("t1_seq_bad", bad, 0);
        check("t1_oldest_f2", von[0], 0);
        check("t1_oldest_f3", von[13], 1);
        check("t1_oldest_f4", von[26], 2);
        check("t1_done", n_done, 1);
        check("t1_busy_end", int'(busy), 0);

        clear_stats();
        pulse_start(6);
        for (int i = 1; i <= 7; i++) begin
            repeat (200) @(posedge clk);
            #1;
            if (i == 5) check("t2_no_rd_before_5", n_rd, 0);
            if (i == 6) check("t2_rd_frame2", n_rd, 52);
            pulse_wr(1);
        end
        wait_done("t2", 1000);
        check("t2_count", n_valid, 39);
        check("t2_rd_total", n_rd, 156);

        clear_stats();
        fill_extreme();
        pulse_start(4);
        pulse_wr(5);
        wait_done("t3", 500);
        check("t3_count", n_valid, 13);
        check("t3_pos", vout[0], 196605);
        check("t3_neg", vout[1], -196605);
        check("t3_pos_k12", vout[12], 196605);
        check("t4_frame", vframe[12], 2);

        clear_stats();
        pulse_start(3);
        wait_done("t4", 50);
        check("t4_no_valid", n_valid, 0);
        check("t4_done", n_done, 1);
        check("t4_busy_cycles", n_busy, 1);

        clear_stats();
        fill_ramp();
        pulse_start(6);
        pulse_wr(7);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (n_valid >= 16) break;
        end
        check("t5_reached_f3", int'(n_valid >= 16 && vframe[15] == 3), 1);
        base = n_valid;
        start = 1'b1;
        last_frame = 7'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_stale", n_valid - base, 0);
        pulse_wr(7);
        wait_done("t5", 1000);
        check("t5_count", n_valid - base, 39);
        check("t5_first_frame", vframe[base], 2);
        check("t5_first_coef", vcoef[base], 0);
        check("t5_done_once", n_done, 1);

        clear_stats();
        pulse_start(6);
        pulse_wr(7);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (n_rd >= 5) break;
        end
        check("t6_pre_rd_en", int'(rd_en), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rd_en", int'(rd_en), 0);
        check("t6_rd_addr", int'(rd_addr), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_out", int'(delta_out), 0);
        check("t6_oldest", int'(oldest_needed), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        pulse_start(4);
        pulse_wr(9);
        wait_done("t6", 500);
        check("t6_count", n_valid, 13);
        check("t6_val", vout[12], 160);
        check("t6_done", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
